// File: rtl/mem_bus_arbiter_pkg.sv
// Types shared by the memory bus arbiter and its grant picker.
`include "config.vh"

package mem_bus_arbiter_pkg;

    typedef enum logic {
        StIdle,
        StBusy
    } arb_state_e;

    typedef struct packed {
        logic [`ADDR_W-1:0]      addr;
        logic [`WORD_W-1:0]      wr_data;
        logic                    wr_en;
        logic [`MEM_COUNT_W-1:0] count;
    } bus_req_t;

    function automatic logic other_port(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/config.vh
// Shared bus constants: widths, access sizes and response codes.
`ifndef CONFIG_VH
`define CONFIG_VH

`define ADDR_W      32
`define WORD_W      32
`define MEM_COUNT_W 2
`define MEM_CODE_W  3

`define MEM_COUNT_BYTE 2'd0
`define MEM_COUNT_HALF 2'd1
`define MEM_COUNT_WORD 2'd2

`define MEM_CODE_NONE          3'd0
`define MEM_CODE_MISALIGNED    3'd1
`define MEM_CODE_OUT_OF_BOUNDS 3'd2
`define MEM_CODE_TIMEOUT       3'd3

`endif

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Combinational two-way grant picker: round-robin or fixed priority to port 1.
module mem_bus_arbiter_rr_arb2
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |valid;
        grant_id    = 1'b0;
        case (valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = (FIXED_PRIO != 0) ? 1'b1 : other_port(last_grant);
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the peripheral bus, one transaction outstanding.
// Optional bus-wait timeout is enabled with the MEM_ARB_TIMEOUT_EN macro.
`include "config.vh"

module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIO     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    areset,

    input  logic                    i_req0_valid,
    input  logic [`ADDR_W-1:0]      i_req0_addr,
    input  logic [`WORD_W-1:0]      i_req0_wr_data,
    input  logic                    i_req0_wr_en,
    input  logic [`MEM_COUNT_W-1:0] i_req0_count,
    output logic                    o_req0_ready,
    output logic                    o_res0_valid,
    output logic [`WORD_W-1:0]      o_res0_rd_data,
    output logic [`MEM_CODE_W-1:0]  o_res0_code,

    input  logic                    i_req1_valid,
    input  logic [`ADDR_W-1:0]      i_req1_addr,
    input  logic [`WORD_W-1:0]      i_req1_wr_data,
    input  logic                    i_req1_wr_en,
    input  logic [`MEM_COUNT_W-1:0] i_req1_count,
    output logic                    o_req1_ready,
    output logic                    o_res1_valid,
    output logic [`WORD_W-1:0]      o_res1_rd_data,
    output logic [`MEM_CODE_W-1:0]  o_res1_code,

    output logic                    o_bus_valid,
    output logic [`ADDR_W-1:0]      o_bus_addr,
    output logic [`WORD_W-1:0]      o_bus_wr_data,
    output logic                    o_bus_wr_en,
    output logic [`MEM_COUNT_W-1:0] o_bus_count,
    input  logic                    i_bus_res_valid,
    input  logic [`WORD_W-1:0]      i_bus_rd_data,
    input  logic [`MEM_CODE_W-1:0]  i_bus_code
);

    arb_state_e             state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   owner_q, owner_d;
    bus_req_t               bus_q, bus_d;
    bus_req_t               req_sel;
    logic                   res0_valid_q, res0_valid_d;
    logic                   res1_valid_q, res1_valid_d;
    logic [`WORD_W-1:0]     res_rd_data_q, res_rd_data_d;
    logic [`MEM_CODE_W-1:0] res_code_q, res_code_d;
    logic                   grant_valid;
    logic                   grant_id;
    logic                   accept;
    logic                   timeout;

    mem_bus_arbiter_rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_rr_arb2 (
        .valid      ({i_req1_valid, i_req0_valid}),
        .last_grant (last_grant_q),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    assign accept = (state_q == StIdle) && grant_valid;

    always_comb begin
        req_sel = '0;
        if (grant_id) begin
            req_sel.addr    = i_req1_addr;
            req_sel.wr_data = i_req1_wr_data;
            req_sel.wr_en   = i_req1_wr_en;
            req_sel.count   = i_req1_count;
        end else begin
            req_sel.addr    = i_req0_addr;
            req_sel.wr_data = i_req0_wr_data;
            req_sel.wr_en   = i_req0_wr_en;
            req_sel.count   = i_req0_count;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Fires on the last allowed BUSY cycle, giving exactly TIMEOUT_CYCLES of bus wait.
    assign timeout = (state_q == StBusy) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == StBusy) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout               = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        bus_d         = bus_q;
        res0_valid_d  = 1'b0;
        res1_valid_d  = 1'b0;
        res_rd_data_d = res_rd_data_q;
        res_code_d    = res_code_q;
        o_req0_ready  = 1'b0;
        o_req1_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                o_req0_ready = grant_valid && !grant_id;
                o_req1_ready = grant_valid && grant_id;
                if (grant_valid) begin
                    bus_d   = req_sel;
                    owner_d = grant_id;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // A real slave response takes precedence over a coincident timeout.
                if (i_bus_res_valid || timeout) begin
                    res0_valid_d  = !owner_q;
                    res1_valid_d  = owner_q;
                    res_rd_data_d = i_bus_res_valid ? i_bus_rd_data : '0;
                    res_code_d    = i_bus_res_valid ? i_bus_code : `MEM_CODE_TIMEOUT;
                    last_grant_d  = owner_q;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            bus_q         <= '0;
            res0_valid_q  <= 1'b0;
            res1_valid_q  <= 1'b0;
            res_rd_data_q <= '0;
            res_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            bus_q         <= bus_d;
            res0_valid_q  <= res0_valid_d;
            res1_valid_q  <= res1_valid_d;
            res_rd_data_q <= res_rd_data_d;
            res_code_q    <= res_code_d;
        end
    end

    // Bus valid decodes straight from state so an asynchronous reset drops it at once.
    assign o_bus_valid    = (state_q == StBusy);
    assign o_bus_addr     = bus_q.addr;
    assign o_bus_wr_data  = bus_q.wr_data;
    assign o_bus_wr_en    = bus_q.wr_en;
    assign o_bus_count    = bus_q.count;

    assign o_res0_valid   = res0_valid_q;
    assign o_res0_rd_data = res_rd_data_q;
    assign o_res0_code    = res_code_q;
    assign o_res1_valid   = res1_valid_q;
    assign o_res1_rd_data = res_rd_data_q;
    assign o_res1_code    = res_code_q;

endmodule
